// File: rtl/ysyx_pkg.sv
// ============================================================================
// Module  : ysyx_pkg
// Brief   : Shared ysyx types: writeback queue entry and FSM state.
// Revision: 1.0 - initial release
// ============================================================================
`include "ysyx.svh"
`default_nettype none

package ysyx_pkg;

    typedef enum logic [0:0] {
        WBU_RUN  = 1'b0,
        WBU_HALT = 1'b1
    } wbu_state_t;

    typedef struct packed {
        logic [`YSYX_XLEN-1:0] pc;
        logic [31:0]           inst;
        logic [`YSYX_XLEN-1:0] npc;
        logic                  change;
        logic                  retire;
        logic                  ebreak;
    } wbu_entry_t;

endpackage

`default_nettype wire

// File: rtl/ysyx.svh
// ysyx shared defines: datapath width, writeback queue depth and DPI hook fallbacks.
`ifndef YSYX_SVH
`define YSYX_SVH
`default_nettype none

`define YSYX_XLEN        32
`define YSYX_WBU_Q_DEPTH 4

// Simulation environments override these with DPI calls; synthesis sees no-ops.
`ifndef YSYX_DPI_C_NPC_EXU_EBREAK
`define YSYX_DPI_C_NPC_EXU_EBREAK
`endif
`ifndef YSYX_DPI_C_NPC_DIFFTEST_SKIP_REF
`define YSYX_DPI_C_NPC_DIFFTEST_SKIP_REF
`endif

`default_nettype wire
`endif

// File: rtl/ysyx_wbu_q_ram.sv
// ============================================================================
// Module  : ysyx_wbu_q_ram
// Brief   : DEPTH x entry storage, one synchronous write port, one async read.
// Revision: 1.0 - initial release
// ============================================================================
`include "ysyx.svh"
`default_nettype none

module ysyx_wbu_q_ram
    import ysyx_pkg::*;
#(
    parameter int DEPTH = `YSYX_WBU_Q_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  wbu_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output wbu_entry_t    rdata
);

    wbu_entry_t r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wen) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/ysyx_wbu_q.sv
// ============================================================================
// Module  : ysyx_wbu_q
// Brief   : Writeback queue with redirect flush and ebreak halt.
//           Optional retire counter enabled by YSYX_WBU_Q_RETIRE_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`include "ysyx.svh"
`default_nettype none

module ysyx_wbu_q
    import ysyx_pkg::*;
#(
    parameter int XLEN  = `YSYX_XLEN,
    parameter int DEPTH = `YSYX_WBU_Q_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_npc,
    input  logic            in_change,
    input  logic            in_retire,
    input  logic            in_ebreak,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_npc,
    output logic            out_change,
    output logic            out_retire,
    output logic            out_halt
`ifdef YSYX_WBU_Q_RETIRE_CNT_EN
    ,
    output logic [63:0]     out_retire_cnt
`endif
);

    localparam int           AW        = $clog2(DEPTH);
    localparam logic [AW:0]  c_FULL    = (AW+1)'(DEPTH);
    localparam logic [0:0]   c_ST_RUN  = WBU_RUN;
    localparam logic [0:0]   c_ST_HALT = WBU_HALT;

    logic [AW:0]   r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [0:0]    r_state;

    wbu_entry_t    w_wr;
    wbu_entry_t    w_rd;
    logic          w_run;
    logic          w_push;
    logic          w_pop;
    logic          w_redirect;
    logic          w_halt_pop;
    logic [AW:0]   w_count_next;

    assign w_wr.pc     = in_pc;
    assign w_wr.inst   = in_inst;
    assign w_wr.npc    = in_npc;
    assign w_wr.change = in_change;
    assign w_wr.retire = in_retire;
    assign w_wr.ebreak = in_ebreak;

    ysyx_wbu_q_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .wen   (w_push),
        .waddr (r_tail),
        .wdata (w_wr),
        .raddr (r_head),
        .rdata (w_rd)
    );

    // A full queue refuses pushes even if it pops in the same cycle.
    assign w_run      = (r_state == c_ST_RUN);
    assign in_ready   = (r_count != c_FULL) && w_run;
    assign out_valid  = (r_count != '0) && w_run;
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_redirect = w_pop && w_rd.change;
    assign w_halt_pop = w_pop && w_rd.ebreak;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (AW+1)'(1);
            2'b01:   w_count_next = r_count - (AW+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_state <= c_ST_RUN;
            `YSYX_DPI_C_NPC_DIFFTEST_SKIP_REF;
        end else begin
            // A redirecting pop drops every younger entry, including this cycle's push.
            if (w_redirect) begin
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                r_count <= w_count_next;
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                if (w_push) begin
                    r_tail <= r_tail + AW'(1);
                end
            end
            if (w_halt_pop) begin
                r_state <= c_ST_HALT;
                `YSYX_DPI_C_NPC_EXU_EBREAK;
            end
        end
    end

    assign out_pc     = w_rd.pc;
    assign out_inst   = w_rd.inst;
    assign out_npc    = w_rd.npc;
    assign out_change = out_valid && w_rd.change;
    assign out_retire = out_valid && w_rd.retire;
    assign out_halt   = (r_state == c_ST_HALT);

`ifdef YSYX_WBU_Q_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retire_cnt <= '0;
        end else if (w_pop && w_rd.retire) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign out_retire_cnt = r_retire_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_wbu_q.sv
// ============================================================================
// Module  : tb_ysyx_wbu_q
// Brief   : Self-checking bench for ysyx_wbu_q against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_wbu_q;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_inst, in_npc;
    logic        in_change, in_retire, in_ebreak;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst, out_npc;
    logic        out_change, out_retire, out_halt;
`ifdef YSYX_WBU_Q_RETIRE_CNT_EN
    logic [63:0] out_retire_cnt;
`endif

    always #5 clock = ~clock;

    ysyx_wbu_q #(
        .XLEN  (32),
        .DEPTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .in_npc     (in_npc),
        .in_change  (in_change),
        .in_retire  (in_retire),
        .in_ebreak  (in_ebreak),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_npc    (out_npc),
        .out_change (out_change),
        .out_retire (out_retire),
        .out_halt   (out_halt)
`ifdef YSYX_WBU_Q_RETIRE_CNT_EN
        ,
        .out_retire_cnt (out_retire_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] npc;
        bit          ch;
        bit          rt;
        bit          eb;
    } ent_t;

    ent_t        mq[$];
    bit          m_halt;
    longint      m_cnt;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] npc,
                                input bit ch, input bit rt, input bit eb);
        ent_t e;
        e.pc = pc; e.inst = $urandom; e.npc = npc; e.ch = ch; e.rt = rt; e.eb = eb;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        logic [31:0] pc;
        bit ch;
        pc = $urandom & 32'hffff_fffc;
        ch = ($urandom_range(0, 9) == 0);
        return mk(pc, ch ? $urandom : pc + 32'd4, ch, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0);
    endfunction

    task automatic check_out();
        bit ev;
        bit er;
        ev = (mq.size() != 0) && !m_halt;
        er = (mq.size() < 4) && !m_halt;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready",  64'(in_ready),  64'(er));
        chk("out_halt",  64'(out_halt),  64'(m_halt));
        if (ev) begin
            chk("out_pc",     64'(out_pc),     64'(mq[0].pc));
            chk("out_inst",   64'(out_inst),   64'(mq[0].inst));
            chk("out_npc",    64'(out_npc),    64'(mq[0].npc));
            chk("out_change", 64'(out_change), 64'(mq[0].ch));
            chk("out_retire", 64'(out_retire), 64'(mq[0].rt));
        end else begin
            chk("out_change_idle", 64'(out_change), 64'd0);
            chk("out_retire_idle", 64'(out_retire), 64'd0);
        end
`ifdef YSYX_WBU_Q_RETIRE_CNT_EN
        chk("retire_cnt", out_retire_cnt, 64'(m_cnt));
`endif
    endtask

    // One clock: check outputs, drive inputs, advance the model at the edge.
    task automatic cyc(input bit v, input ent_t e, input bit ordy);
        bit   push;
        bit   pop;
        ent_t head;
        check_out();
        in_valid  = v;
        in_pc     = e.pc;
        in_inst   = e.inst;
        in_npc    = e.npc;
        in_change = e.ch;
        in_retire = e.rt;
        in_ebreak = e.eb;
        out_ready = ordy;
        push = v && (mq.size() < 4) && !m_halt;
        pop  = (mq.size() != 0) && !m_halt && ordy;
        @(posedge clock);
        if (pop) begin
            head = mq.pop_front();
            if (head.rt) m_cnt++;
            if (head.eb) m_halt = 1'b1;
        end
        if (push) mq.push_back(e);
        if (pop && head.ch) mq.delete();
        @(negedge clock);
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0), ordy);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        mq.delete();
        m_halt = 1'b0;
        m_cnt  = 0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0; in_npc = '0;
        in_change = 1'b0; in_retire = 1'b0; in_ebreak = 1'b0;
        @(negedge clock);
        do_reset();

        // empty-queue latency
        cyc(1'b1, mk(32'h8000_0000, 32'h8000_0004, 1'b0, 1'b1, 1'b0), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // fill, rejected pushes when full, then wrap
        for (int i = 0; i < 4; i++) cyc(1'b1, mk(32'h10 + 4*i, 32'h14 + 4*i, 1'b0, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(32'h40, 32'h44, 1'b0, 1'b0, 1'b0), 1'b0);
        cyc(1'b1, mk(32'h44, 32'h48, 1'b0, 1'b0, 1'b0), 1'b1);
        idle(1'b1);
        cyc(1'b1, mk(32'h50, 32'h54, 1'b0, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(32'h54, 32'h58, 1'b0, 1'b1, 1'b0), 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // redirect flushes younger entries and a same-cycle push
        cyc(1'b1, mk(32'h100, 32'h200, 1'b1, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(32'h104, 32'h108, 1'b0, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(32'h108, 32'h10c, 1'b0, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(32'h10c, 32'h110, 1'b0, 1'b1, 1'b0), 1'b1);
        idle(1'b1);

        // backpressure holds the head
        cyc(1'b1, mk(32'h200, 32'h204, 1'b0, 1'b1, 1'b0), 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // ebreak halts with in_valid held, reset recovers
        cyc(1'b1, mk(32'h300, 32'h304, 1'b0, 1'b1, 1'b1), 1'b1);
        cyc(1'b1, mk(32'h304, 32'h308, 1'b0, 1'b1, 1'b0), 1'b1);
        cyc(1'b1, mk(32'h308, 32'h30c, 1'b0, 1'b1, 1'b0), 1'b1);
        cyc(1'b1, mk(32'h30c, 32'h310, 1'b0, 1'b1, 1'b0), 1'b1);
        do_reset();
        idle(1'b1);

        // ebreak entry that also redirects
        cyc(1'b1, mk(32'h400, 32'h800, 1'b1, 1'b0, 1'b1), 1'b0);
        cyc(1'b1, mk(32'h404, 32'h408, 1'b0, 1'b0, 1'b0), 1'b1);
        idle(1'b1);
        do_reset();

        // retire counter: pattern 1,0,1,0,1
        for (int i = 0; i < 5; i++) cyc(1'b1, mk(32'h500 + 4*i, 32'h504 + 4*i, 1'b0, (i % 2) == 0, 1'b0), 1'b1);
        idle(1'b1);
        idle(1'b1);
`ifdef YSYX_WBU_Q_RETIRE_CNT_EN
        chk("retire_cnt_3", out_retire_cnt, 64'd3);
`endif

        // randomized traffic with occasional mid-run resets
        for (int i = 0; i < 600; i++) begin
            if (m_halt && $urandom_range(0, 3) == 0) do_reset();
            else if ($urandom_range(0, 149) == 0) do_reset();
            else cyc($urandom_range(0, 2) != 0, rnd_ent(), $urandom_range(0, 3) != 0);
        end
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_wbu_q.md
YSYX_WBU_Q -- requirements
Module: ysyx_wbu_q

Interface
REQ-001 SHALL have parameter XLEN, default `YSYX_XLEN (32), meaning the width of pc and npc.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; it is a power of 2 and at least 2.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have inputs in_valid (1), in_pc (XLEN), in_inst (32), in_npc (XLEN), in_change (1), in_retire (1) and in_ebreak (1): the upstream writeback entry.
REQ-006 SHALL have output in_ready, 1 bit: the queue accepts an entry this cycle.
REQ-007 SHALL have output out_valid, 1 bit, and input out_ready, 1 bit: the downstream handshake.
REQ-008 SHALL have outputs out_pc (XLEN), out_inst (32), out_npc (XLEN), out_change (1) and out_retire (1): fields of the head entry.
REQ-009 SHALL have output out_halt, 1 bit: ebreak has committed.

Function
REQ-010 SHALL push on in_valid && in_ready and pop on out_valid && out_ready; each is evaluated per cycle.
REQ-011 SHALL take a pushed entry into an empty queue to out_valid=1 on the next cycle; latency is 1 cycle, with no same-cycle bypass.
REQ-012 SHALL drive in_ready = (count < DEPTH) && state==RUN; a full queue deasserts in_ready even when a pop occurs in the same cycle.
REQ-013 SHALL, on a simultaneous push and pop with 0 < count < DEPTH, perform both and leave count unchanged.
REQ-014 SHALL drive out_valid = (count != 0) && state==RUN.
REQ-015 SHALL force out_change and out_retire to 0 whenever out_valid=0.
REQ-016 SHALL hold out_pc, out_inst and out_npc stable while out_valid && !out_ready.
REQ-017 SHALL store each entry as {pc, inst, npc, change, retire, ebreak}; head and tail pointers are $clog2(DEPTH) bits, wrap modulo DEPTH, and count is $clog2(DEPTH)+1 bits.
REQ-018 SHALL treat a popped entry with change=1 as a redirect: in the same edge it discards all younger entries, and also any entry pushed that cycle, leaving count=0.
REQ-019 SHALL use FSM states RUN and HALT.
REQ-020 SHALL transition RUN->HALT when an entry with ebreak=1 pops, and SHALL invoke `YSYX_DPI_C_NPC_EXU_EBREAK once at that edge.
REQ-021 SHALL, in HALT, hold in_ready=0, out_valid=0 and out_halt=1, and leave HALT only through reset.
REQ-022 SHALL apply REQ-018 discarding when the popped ebreak entry also has change=1.

Reset
REQ-023 SHALL, while reset=1 at an edge, set count=0, head=0, tail=0 and state=RUN, and ignore any push or pop.
REQ-024 SHALL therefore hold out_valid=0, out_change=0, out_retire=0, out_halt=0 and in_ready=1 in the cycle after reset.
REQ-025 SHALL invoke `YSYX_DPI_C_NPC_DIFFTEST_SKIP_REF during reset.
REQ-026 SHALL discard the queue contents on reset asserted mid-operation, including the HALT state; stored payload RAM need not be cleared.

Configuration
REQ-027 SHALL, with YSYX_WBU_Q_RETIRE_CNT_EN defined, add output out_retire_cnt (64 bits), reset to 0 and incremented by 1 on every pop with retire=1.
REQ-028 SHALL, without YSYX_WBU_Q_RETIRE_CNT_EN, have no counter logic and no out_retire_cnt port.

Structure
REQ-029 SHALL place the entry struct typedef (wbu_entry_t) and the FSM enum (wbu_state_t) in the shared ysyx package; the DEPTH default lives in ysyx.svh.
REQ-030 SHALL implement storage as one sub-module, ysyx_wbu_q_ram: DEPTH x entry, 1 write port and 1 asynchronous read port; all control stays in ysyx_wbu_q.

Verification
REQ-031 SHALL test empty-queue latency: push pc=0x80000000 at cycle 0 with out_ready=1 -> out_valid=1 and out_pc=0x80000000 at cycle 1, and out_valid=0 at cycle 2.
REQ-032 SHALL test fill and wrap: with DEPTH=4 and out_ready=0, push 4 entries -> in_ready=0 after the 4th; then pop 2, push 2 -> the pop order is preserved across the wrap.
REQ-033 SHALL test redirect: queue holding pc 0x100, 0x104, 0x108 with 0x100 change=1 and npc=0x200, plus a push that same cycle -> next cycle count=0 and out_valid=0.
REQ-034 SHALL test ebreak: pop an entry with ebreak=1 -> the next cycle has out_halt=1, in_ready=0 and out_valid=0 while in_valid=1 is held; reset -> out_halt=0 and in_ready=1.
REQ-035 SHALL test backpressure: out_ready=0 for 5 cycles with head pc=0x200 -> out_pc stays 0x200 with out_valid=1 throughout.
REQ-036 SHALL test the counter with YSYX_WBU_Q_RETIRE_CNT_EN defined: 3 pops with retire=1 and 2 pops with retire=0 -> out_retire_cnt=3.
